// File: rtl/bcp_engine_multi_if.sv
// Handshake and data bundle between the BCP engine and its controller/loader.
// The master side drives loads and start requests; the slave side is the engine.
interface bcp_engine_multi_if #(
  parameter int VAR_NUM   = 8,
  parameter int VAR_AW    = 3,
  parameter int CLAUSE_AW = 2
);
  logic                 load_en;
  logic [CLAUSE_AW-1:0] load_addr;
  logic [VAR_NUM-1:0]   load_mask;
  logic [VAR_NUM-1:0]   load_type;
  logic                 bcp_engine_en;
  logic [VAR_NUM-1:0]   assignment;
  logic [VAR_NUM-1:0]   free;

  logic                 busy;
  logic                 bcp_finish;
  logic                 conflict;
  logic [CLAUSE_AW-1:0] conflict_clause;
  logic                 impl_valid;
  logic [VAR_AW-1:0]    impl_var;
  logic                 impl_value;
  logic [CLAUSE_AW-1:0] impl_clause;
  logic [VAR_AW:0]      impl_count;
  logic [VAR_NUM-1:0]   assignment_out;
  logic [VAR_NUM-1:0]   free_out;

  modport master (
    output load_en, load_addr, load_mask, load_type, bcp_engine_en, assignment, free,
    input  busy, bcp_finish, conflict, conflict_clause, impl_valid, impl_var,
           impl_value, impl_clause, impl_count, assignment_out, free_out
  );

  modport slave (
    input  load_en, load_addr, load_mask, load_type, bcp_engine_en, assignment, free,
    output busy, bcp_finish, conflict, conflict_clause, impl_valid, impl_var,
           impl_value, impl_clause, impl_count, assignment_out, free_out
  );
endinterface

// File: rtl/bcp_engine_multi.sv
// Multi-clause Boolean constraint propagation engine: scans one stored clause per
// cycle, applies unit implications in place and rescans until fixpoint or conflict.
module bcp_engine_multi #(
  parameter int VAR_NUM    = 8,
  parameter int VAR_AW     = 3,
  parameter int CLAUSE_NUM = 4,
  parameter int CLAUSE_AW  = 2
) (
  input logic               clock,
  input logic               reset,
  bcp_engine_multi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  localparam logic [CLAUSE_AW-1:0] LAST_PTR = CLAUSE_AW'(CLAUSE_NUM - 1);
  localparam logic [CLAUSE_AW-1:0] PTR_ONE  = CLAUSE_AW'(1);
  localparam logic [VAR_AW:0]      CNT_ONE  = (VAR_AW + 1)'(1);
  localparam logic [VAR_AW:0]      CNT_ZERO = '0;

  state_t               state_q, state_d;
  logic [VAR_NUM-1:0]   mask_q [CLAUSE_NUM];
  logic [VAR_NUM-1:0]   type_q [CLAUSE_NUM];
  logic [VAR_NUM-1:0]   asg_q, asg_d;
  logic [VAR_NUM-1:0]   free_q, free_d;
  logic [CLAUSE_AW-1:0] ptr_q, ptr_d;
  logic                 changed_q, changed_d;
  logic                 conflict_q, conflict_d;
  logic [CLAUSE_AW-1:0] cclause_q, cclause_d;
  logic                 impl_valid_q, impl_valid_d;
  logic [VAR_AW-1:0]    impl_var_q, impl_var_d;
  logic                 impl_value_q, impl_value_d;
  logic [CLAUSE_AW-1:0] impl_clause_q, impl_clause_d;
  logic [VAR_AW:0]      cnt_q, cnt_d;

  logic                 store_we;
  logic [VAR_NUM-1:0]   cur_mask, cur_type;
  logic                 sat, active, is_unit, is_conf;
  logic [VAR_AW:0]      nfree;
  logic [VAR_AW-1:0]    unit_var;

  assign store_we = (state_q == IDLE) && bus.load_en;

  // Evaluate the clause under the pointer against the working assignment.
  always_comb begin
    cur_mask = mask_q[ptr_q];
    cur_type = type_q[ptr_q];
    sat      = 1'b0;
    nfree    = CNT_ZERO;
    unit_var = '0;
    for (int i = 0; i < VAR_NUM; i++) begin
      if (cur_mask[i]) begin
        if (free_q[i]) begin
          nfree    = nfree + CNT_ONE;
          unit_var = VAR_AW'(i);
        end else if (asg_q[i] == cur_type[i]) begin
          sat = 1'b1;
        end
      end
    end
    active  = |cur_mask;
    is_unit = active && !sat && (nfree == CNT_ONE);
    is_conf = active && !sat && (nfree == CNT_ZERO);
  end

  always_comb begin
    state_d       = state_q;
    asg_d         = asg_q;
    free_d        = free_q;
    ptr_d         = ptr_q;
    changed_d     = changed_q;
    conflict_d    = conflict_q;
    cclause_d     = cclause_q;
    impl_valid_d  = 1'b0;
    impl_var_d    = impl_var_q;
    impl_value_d  = impl_value_q;
    impl_clause_d = impl_clause_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.bcp_engine_en) begin
          asg_d      = bus.assignment;
          free_d     = bus.free;
          conflict_d = 1'b0;
          cnt_d      = CNT_ZERO;
          changed_d  = 1'b0;
          ptr_d      = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (is_conf) begin
          conflict_d = 1'b1;
          cclause_d  = ptr_q;
          state_d    = FINISH;
        end else begin
          if (is_unit) begin
            asg_d[unit_var]  = cur_type[unit_var];
            free_d[unit_var] = 1'b0;
            impl_valid_d     = 1'b1;
            impl_var_d       = unit_var;
            impl_value_d     = cur_type[unit_var];
            impl_clause_d    = ptr_q;
            cnt_d            = cnt_q + CNT_ONE;
          end
          // An implication on the last slot still counts toward another pass.
          if (ptr_q == LAST_PTR) begin
            if (changed_q || is_unit) begin
              changed_d = 1'b0;
              ptr_d     = '0;
            end else begin
              state_d = FINISH;
            end
          end else begin
            ptr_d = ptr_q + PTR_ONE;
            if (is_unit) changed_d = 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      asg_q         <= '0;
      free_q        <= '1;
      ptr_q         <= '0;
      changed_q     <= 1'b0;
      conflict_q    <= 1'b0;
      cclause_q     <= '0;
      impl_valid_q  <= 1'b0;
      impl_var_q    <= '0;
      impl_value_q  <= 1'b0;
      impl_clause_q <= '0;
      cnt_q         <= CNT_ZERO;
      for (int c = 0; c < CLAUSE_NUM; c++) begin
        mask_q[c] <= '0;
        type_q[c] <= '0;
      end
    end else begin
      state_q       <= state_d;
      asg_q         <= asg_d;
      free_q        <= free_d;
      ptr_q         <= ptr_d;
      changed_q     <= changed_d;
      conflict_q    <= conflict_d;
      cclause_q     <= cclause_d;
      impl_valid_q  <= impl_valid_d;
      impl_var_q    <= impl_var_d;
      impl_value_q  <= impl_value_d;
      impl_clause_q <= impl_clause_d;
      cnt_q         <= cnt_d;
      if (store_we) begin
        mask_q[bus.load_addr] <= bus.load_mask;
        type_q[bus.load_addr] <= bus.load_type;
      end
    end
  end

  assign bus.busy            = (state_q == SCAN);
  assign bus.bcp_finish      = (state_q == FINISH);
  assign bus.conflict        = conflict_q;
  assign bus.conflict_clause = cclause_q;
  assign bus.impl_valid      = impl_valid_q;
  assign bus.impl_var        = impl_var_q;
  assign bus.impl_value      = impl_value_q;
  assign bus.impl_clause     = impl_clause_q;
  assign bus.impl_count      = cnt_q;
  assign bus.assignment_out  = asg_q;
  assign bus.free_out        = free_q;

endmodule

// File: tb/tb_bcp_engine_multi.sv
// Scoreboard bench for bcp_engine_multi: directed runs push expected implications and
// completion records; a negedge monitor pops and compares them as the engine emits.
module tb_bcp_engine_multi;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bcp_engine_multi_if #(.VAR_NUM(8), .VAR_AW(3), .CLAUSE_AW(2)) bif ();

  bcp_engine_multi #(.VAR_NUM(8), .VAR_AW(3), .CLAUSE_NUM(4), .CLAUSE_AW(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  typedef struct {
    bit         is_fin;
    logic [2:0] v;
    logic       val;
    logic [1:0] cl;
    logic       conf;
    logic [1:0] ccl;
    logic [3:0] cnt;
    logic [7:0] asg;
    logic [7:0] fr;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fin_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event not expected or missing at cycle %0d", nm, cyc);
  endtask

  task automatic push_impl(input logic [2:0] v, input logic val, input logic [1:0] cl);
    exp_t e;
    e = '{default: 0};
    e.is_fin = 1'b0; e.v = v; e.val = val; e.cl = cl;
    sb.push_back(e);
  endtask

  task automatic push_fin(input logic conf, input logic [1:0] ccl, input logic [3:0] cnt,
                          input logic [7:0] asg, input logic [7:0] fr, input int lat);
    exp_t e;
    e = '{default: 0};
    e.is_fin = 1'b1; e.conf = conf; e.ccl = ccl; e.cnt = cnt;
    e.asg = asg; e.fr = fr; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] m, input logic [7:0] t);
    @(negedge clock);
    bif.load_en = 1'b1; bif.load_addr = a; bif.load_mask = m; bif.load_type = t;
    @(negedge clock);
    bif.load_en = 1'b0;
  endtask

  task automatic start(input logic [7:0] asg, input logic [7:0] fr, input bit with_load,
                       input logic [1:0] a, input logic [7:0] m, input logic [7:0] t);
    @(negedge clock);
    bif.assignment = asg; bif.free = fr; bif.bcp_engine_en = 1'b1;
    if (with_load) begin
      bif.load_en = 1'b1; bif.load_addr = a; bif.load_mask = m; bif.load_type = t;
    end
    start_cyc = cyc + 1;
    @(negedge clock);
    bif.bcp_engine_en = 1'b0;
    bif.load_en = 1'b0;
  endtask

  task automatic wait_fin(input string nm);
    int f0;
    int n;
    f0 = fin_cnt;
    n = 0;
    while (fin_cnt == f0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (fin_cnt == f0) flag({nm, "_timeout"});
  endtask

  // Monitor: compare each emitted implication / completion against the queue head.
  always @(negedge clock) begin
    if (reset) begin
      if (bif.impl_valid) begin
        if (sb.size() == 0 || sb[0].is_fin) flag("unexpected_impl_valid");
        else begin
          me = sb.pop_front();
          check("impl_var", bif.impl_var, me.v);
          check("impl_value", bif.impl_value, me.val);
          check("impl_clause", bif.impl_clause, me.cl);
        end
      end
      if (bif.bcp_finish) begin
        fin_cnt++;
        if (sb.size() == 0 || !sb[0].is_fin) begin
          flag("unexpected_finish_or_missing_impl");
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          me = sb.pop_front();
          check("finish_latency", cyc - start_cyc, me.lat);
          check("busy_at_finish", bif.busy, 0);
          check("conflict", bif.conflict, me.conf);
          if (me.conf) check("conflict_clause", bif.conflict_clause, me.ccl);
          check("impl_count", bif.impl_count, me.cnt);
          check("assignment_out", bif.assignment_out, me.asg);
          check("free_out", bif.free_out, me.fr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    bif.load_en = 1'b0; bif.load_addr = '0; bif.load_mask = '0; bif.load_type = '0;
    bif.bcp_engine_en = 1'b0; bif.assignment = '0; bif.free = '0;

    #12;
    check("rst_busy", bif.busy, 0);
    check("rst_finish", bif.bcp_finish, 0);
    check("rst_impl_valid", bif.impl_valid, 0);
    check("rst_conflict", bif.conflict, 0);
    check("rst_free_out", bif.free_out, 8'hFF);
    check("rst_assignment_out", bif.assignment_out, 8'h00);
    check("rst_impl_count", bif.impl_count, 0);
    @(negedge clock);
    reset = 1'b1;

    // Reset mid-scan: C0 is loaded, then wiped by the reset.
    load(2'd0, 8'h03, 8'h01);
    start(8'h01, 8'hFE, 1'b0, 2'd0, 8'h00, 8'h00);
    check("busy_in_scan", bif.busy, 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", bif.busy, 0);
    check("abort_finish", bif.bcp_finish, 0);
    check("abort_impl_valid", bif.impl_valid, 0);
    check("abort_free_out", bif.free_out, 8'hFF);
    check("abort_assignment_out", bif.assignment_out, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    push_fin(1'b0, 2'd0, 4'd0, 8'h02, 8'h00, 4);
    start(8'h02, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00);
    wait_fin("post_reset");

    // Chained implications, no C2.
    load(2'd0, 8'h03, 8'h01);
    load(2'd1, 8'h05, 8'h04);
    push_impl(3'd0, 1'b1, 2'd0);
    push_impl(3'd2, 1'b1, 2'd1);
    push_fin(1'b0, 2'd0, 4'd2, 8'h07, 8'hF8, 8);
    start(8'h02, 8'hFD, 1'b0, 2'd0, 8'h00, 8'h00);
    wait_fin("chain");

    // Same run with C2 loaded: conflict at clause 2.
    load(2'd2, 8'h06, 8'h00);
    push_impl(3'd0, 1'b1, 2'd0);
    push_impl(3'd2, 1'b1, 2'd1);
    push_fin(1'b1, 2'd2, 4'd2, 8'h07, 8'hF8, 3);
    start(8'h02, 8'hFD, 1'b0, 2'd0, 8'h00, 8'h00);
    wait_fin("conflict");
    repeat (3) @(negedge clock);
    check("conflict_held", bif.conflict, 1);
    check("conflict_clause_held", bif.conflict_clause, 2);

    // Rescan: second implication only becomes visible on pass 2.
    load(2'd0, 8'h05, 8'h04);
    load(2'd1, 8'h03, 8'h01);
    load(2'd2, 8'h00, 8'h00);
    push_impl(3'd0, 1'b1, 2'd1);
    push_impl(3'd2, 1'b1, 2'd0);
    push_fin(1'b0, 2'd0, 4'd2, 8'h07, 8'hF8, 12);
    start(8'h02, 8'hFD, 1'b0, 2'd0, 8'h00, 8'h00);
    wait_fin("rescan");

    // All-free run, with load/start attempts while busy.
    load(2'd0, 8'h03, 8'h01);
    load(2'd1, 8'h00, 8'h00);
    push_fin(1'b0, 2'd0, 4'd0, 8'h00, 8'hFF, 4);
    start(8'h00, 8'hFF, 1'b0, 2'd0, 8'h00, 8'h00);
    bif.load_en = 1'b1; bif.load_addr = 2'd1; bif.load_mask = 8'h01; bif.load_type = 8'h00;
    bif.bcp_engine_en = 1'b1; bif.assignment = 8'hFF; bif.free = 8'h00;
    repeat (2) @(negedge clock);
    bif.load_en = 1'b0; bif.bcp_engine_en = 1'b0;
    wait_fin("interlock");

    // C0 satisfied by x0 = 1; a leaked load into C1 would conflict here.
    push_fin(1'b0, 2'd0, 4'd0, 8'h01, 8'hFE, 4);
    start(8'h01, 8'hFE, 1'b0, 2'd0, 8'h00, 8'h00);
    wait_fin("satisfied");

    // Load together with start: the new C1 = (~x0) conflicts.
    push_fin(1'b1, 2'd1, 4'd0, 8'h01, 8'hFE, 2);
    start(8'h01, 8'hFE, 1'b1, 2'd1, 8'h01, 8'h00);
    wait_fin("load_with_start");

    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcp_engine_multi.md
Name: bcp_engine_multi

Overview:
- Parametrised successor to the single-clause BCP engine.
- Holds CLAUSE_NUM clauses over VAR_NUM variables in an internal clause store and, on start, runs Boolean constraint propagation to fixpoint.
- Scans one clause per cycle, applies unit implications to a working assignment, rescans until a pass yields nothing new, and reports either completion or the first conflicting clause.
- Sits between the decision/assignment logic and the clause database loader of the SAT datapath.

Parameters:
- VAR_NUM, 8, number of variables; width of mask/type/assignment vectors.
- VAR_AW, 3, index width for variables; must satisfy 2**VAR_AW >= VAR_NUM.
- CLAUSE_NUM, 4, number of clause slots.
- CLAUSE_AW, 2, clause index width; must satisfy 2**CLAUSE_AW >= CLAUSE_NUM.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  write clause slot; honoured only in IDLE.
- load_addr  in  CLAUSE_AW  clause slot to write.
- load_mask  in  VAR_NUM  1 = variable appears in the clause.
- load_type  in  VAR_NUM  literal polarity: 1 = positive, 0 = negated.
- bcp_engine_en  in  1  start request; sampled only in IDLE.
- assignment  in  VAR_NUM  variable values, captured on start.
- free  in  VAR_NUM  1 = variable unassigned, captured on start.
- busy  out  1  high while in SCAN.
- bcp_finish  out  1  one-cycle pulse on completion (conflict or fixpoint).
- conflict  out  1  held until the next accepted start.
- conflict_clause  out  CLAUSE_AW  index of the conflicting clause, valid while conflict = 1.
- impl_valid  out  1  one-cycle pulse per implication.
- impl_var  out  VAR_AW  implied variable index.
- impl_value  out  1  implied value.
- impl_clause  out  CLAUSE_AW  clause that forced the implication.
- impl_count  out  VAR_AW+1  implications made in the current run.
- assignment_out  out  VAR_NUM  working assignment.
- free_out  out  VAR_NUM  working free vector.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; all outputs 0.
  - free_out = all 1s; clause store masks = 0.
- Clause evaluation, combinational on slot ptr against the working vectors:
  - A literal i is present when mask[i] = 1.
  - sat = any present, assigned literal with assignment[i] == type[i].
  - nfree = count of present literals with free[i] = 1.
  - mask == 0: inactive slot, skipped (no conflict, no implication).
- IDLE:
  - load_en writes mask/type to load_addr.
  - bcp_engine_en = 1 captures assignment/free, clears conflict, impl_count and the changed flag, sets ptr = 0, and enters SCAN.
  - Load and start in the same cycle: the write lands first; the scan sees the new clause.
- SCAN, one clause per cycle:
  - sat = 1, or nfree >= 2: no action.
  - !sat and nfree = 1 (unit):
    - Same edge: free_out[v] <= 0, assignment_out[v] <= type[v].
    - Pulse impl_valid with impl_var = v, impl_value = type[v], impl_clause = ptr.
    - impl_count++ and changed = 1.
    - Later clauses in the same pass see the update.
  - !sat and nfree = 0 (active clause): conflict <= 1, conflict_clause <= ptr, go to FINISH immediately; the remaining clauses are not scanned.
  - ptr == CLAUSE_NUM-1 with no conflict:
    - changed = 1: clear changed, ptr = 0, start a new pass.
    - changed = 0: go to FINISH.
  - Otherwise ptr++.
- FINISH:
  - bcp_finish = 1 for exactly one cycle; busy = 0; return to IDLE.
  - Outputs hold until the next start.
- Latency and handshake:
  - Start at edge k: busy = 1 from edge k.
  - No-implication run: bcp_finish is high in the cycle after edge k+CLAUSE_NUM.
  - Total SCAN cycles = passes × CLAUSE_NUM, with at most VAR_NUM+1 passes, since each implication consumes one free variable.
- Interlocks:
  - load_en and bcp_engine_en are ignored while busy or in FINISH.
  - Reset mid-scan aborts immediately to reset values; the clause store is cleared.
- Widths: impl_count never wraps, because it is at most VAR_NUM.

Test Plan (VAR_NUM = 8, CLAUSE_NUM = 4; C0 = (x0 ∨ ¬x1), C1 = (¬x0 ∨ x2), C2 = (¬x2 ∨ ¬x1), C3 empty):
- Reset mid-SCAN:
  - Stimulus: assert reset low mid-SCAN.
  - Response: busy/impl_valid/bcp_finish drop to 0 asynchronously; free_out = 8'hFF; a subsequent start with no loads gives bcp_finish after 4 scan cycles, conflict = 0, impl_count = 0.
- Chained implication, then conflict:
  - Stimulus: load C0/C1 only; start with assignment = 8'b0000_0010, free = 8'b1111_1101.
  - Response: impl_valid twice, (var 0, val 1, clause 0) then (var 2, val 1, clause 1), in a single pass; C2 is also loaded (by the next case) — without C2 the run ends with assignment_out = 8'b0000_0111, free_out = 8'b1111_1000, impl_count = 2, and bcp_finish after 2 passes (8 scan cycles).
- Conflict:
  - Stimulus: add C2, repeat the previous case.
  - Response: implications as before; C2 then evaluates to all-false, so conflict = 1, conflict_clause = 2, and bcp_finish arrives on the 3rd scan cycle of pass 1; impl_count = 2.
- Rescan:
  - Stimulus: load C0 = (¬x0 ∨ x2), C1 = (x0 ∨ ¬x1), C2/C3 empty; start with x1 = 1 assigned and the rest free.
  - Response: pass 1 implies x0 = 1 at clause 1; pass 2 implies x2 = 1 at clause 0; pass 3 is clean; bcp_finish after 12 scan cycles; impl_count = 2.
- Satisfied / not-unit:
  - Stimulus: all variables free, or C0 already satisfied by x0 = 1.
  - Response: no impl_valid; bcp_finish after 4 cycles; outputs equal the captured inputs.
- Interlock:
  - Stimulus: assert load_en and bcp_engine_en while busy.
  - Response: the clause store is unchanged and the run completes undisturbed; a start together with load in IDLE uses the newly written clause.
